// File: rtl/tcb_rsp_queue.sv
// Response-side tracker for TCB transfers with variable subordinate latency.
// Ports: clk/rst, man_* request side, sub_vld/sub_rdy, rsp_vld in, rsp_* metadata out, cnt/full/empty/err status.
module tcb_rsp_queue #(
  parameter int unsigned ABW   = 32,
  parameter int unsigned DBW   = 32,
  parameter int unsigned SLW   = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SZW   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       man_vld,
  output logic                       man_rdy,
  input  logic                       man_wen,
  input  logic [ABW-1:0]             man_adr,
  input  logic [SZW-1:0]             man_siz,
  input  logic [DBW/SLW-1:0]         man_ben,
  output logic                       sub_vld,
  input  logic                       sub_rdy,
  input  logic                       rsp_vld,
  output logic                       rsp_ena,
  output logic                       rsp_ren,
  output logic [ABW-1:0]             rsp_adr,
  output logic [SZW-1:0]             rsp_siz,
  output logic [DBW/SLW-1:0]         rsp_ben,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int unsigned BEW = DBW / SLW;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned EW  = 1 + ABW + SZW + BEW;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          full_q;
  logic          empty_q;
  logic          err_q;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] entry;
  logic [EW-1:0] head;

  logic pop;
  logic push;
  logic space;

  // A response on an empty queue is never matched to a same-cycle push:
  // the subordinate needs at least one cycle, so it is a protocol error.
  assign pop   = rsp_vld & ~empty_q;
  assign space = ~full_q | pop;

  assign sub_vld = man_vld & space;
  assign man_rdy = sub_rdy & space;
  assign push    = man_vld & man_rdy;

  // Writes carry no byte enables back to the manager.
  assign entry = {~man_wen, man_adr, man_siz,
                  man_wen ? {BEW{1'b0}} : man_ben};

  always_comb begin
    cnt_nxt = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt_q + CW'(1);
      2'b01:   cnt_nxt = cnt_q - CW'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(DEPTH));
      empty_q <= (cnt_nxt == '0);
      if (rsp_vld & empty_q) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign head = mem[rd_ptr];

  assign rsp_ena = pop;
  assign rsp_ren = head[EW-1];
  assign rsp_adr = head[EW-2 -: ABW];
  assign rsp_siz = head[BEW+SZW-1 -: SZW];
  assign rsp_ben = pop ? head[BEW-1:0] : {BEW{1'b0}};

  assign cnt   = cnt_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

endmodule

// File: tb/tb_tcb_rsp_queue.sv
// Self-checking bench for tcb_rsp_queue.
// Table-driven fill/drain vectors plus hand sequences; metadata via scoreboard.
module tb_tcb_rsp_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        man_vld = 1'b0;
  logic        man_rdy;
  logic        man_wen = 1'b0;
  logic [31:0] man_adr = '0;
  logic [1:0]  man_siz = 2'd2;
  logic [3:0]  man_ben = '0;
  logic        sub_vld;
  logic        sub_rdy = 1'b0;
  logic        rsp_vld = 1'b0;
  logic        rsp_ena;
  logic        rsp_ren;
  logic [31:0] rsp_adr;
  logic [1:0]  rsp_siz;
  logic [3:0]  rsp_ben;
  logic [2:0]  cnt;
  logic        full;
  logic        empty;
  logic        err;

  tcb_rsp_queue #(
    .ABW(32), .DBW(32), .SLW(8), .DEPTH(DEPTH), .SZW(2)
  ) dut (
    .clk(clk), .rst(rst),
    .man_vld(man_vld), .man_rdy(man_rdy), .man_wen(man_wen),
    .man_adr(man_adr), .man_siz(man_siz), .man_ben(man_ben),
    .sub_vld(sub_vld), .sub_rdy(sub_rdy),
    .rsp_vld(rsp_vld), .rsp_ena(rsp_ena), .rsp_ren(rsp_ren),
    .rsp_adr(rsp_adr), .rsp_siz(rsp_siz), .rsp_ben(rsp_ben),
    .cnt(cnt), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ren;
    logic [31:0] adr;
    logic [1:0]  siz;
    logic [3:0]  ben;
  } meta_t;

  typedef struct {
    logic        vld;
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic        rsp;
    logic        srdy;
    logic        exp_rdy;
    int          exp_cnt;
  } vec_t;

  meta_t sb[$];
  int    m_cnt = 0;
  logic  m_err = 1'b0;
  logic  seen_rdy;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step(input logic r, input logic v, input logic w,
                      input logic [31:0] a, input logic [3:0] b,
                      input logic rs, input logic sr);
    logic  e_pop, e_space, e_rdy, e_push, e_err;
    meta_t m;
    @(negedge clk);
    rst = r; man_vld = v; man_wen = w; man_adr = a;
    man_ben = b; man_siz = 2'd2; rsp_vld = rs; sub_rdy = sr;
    #1;
    e_pop   = rs && (m_cnt != 0);
    e_space = (m_cnt != DEPTH) || e_pop;
    e_rdy   = sr && e_space;
    e_push  = v && e_rdy;
    e_err   = rs && (m_cnt == 0);
    seen_rdy = man_rdy;
    if (!r) begin
      chk("man_rdy", man_rdy, e_rdy);
      chk("sub_vld", sub_vld, v && e_space);
      chk("rsp_ena", rsp_ena, e_pop);
      if (e_pop) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          m = sb.pop_front();
          chk("rsp_ren", rsp_ren, m.ren);
          chk("rsp_adr", rsp_adr, m.adr);
          chk("rsp_siz", rsp_siz, m.siz);
          chk("rsp_ben", rsp_ben, m.ben);
        end
      end else begin
        chk("rsp_ben_idle", rsp_ben, 0);
      end
      if (e_push) sb.push_back({~w, a, 2'd2, w ? 4'h0 : b});
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt = 0;
      m_err = 1'b0;
      sb.delete();
    end else begin
      m_cnt = m_cnt + int'(e_push) - int'(e_pop);
      if (e_err) m_err = 1'b1;
    end
    chk("cnt", cnt, m_cnt);
    chk("full", full, m_cnt == DEPTH);
    chk("empty", empty, m_cnt == 0);
    chk("err", err, m_err);
  endtask

  function automatic vec_t mkv(logic v, logic w, logic [31:0] a,
                               logic [3:0] b, logic rs, logic sr,
                               logic er, int ec);
    vec_t t;
    t.vld = v; t.wen = w; t.adr = a; t.ben = b;
    t.rsp = rs; t.srdy = sr; t.exp_rdy = er; t.exp_cnt = ec;
    return t;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mkv(1, 0, 32'h00, 4'hF, 0, 1, 1, 1);
    tbl[1]  = mkv(1, 0, 32'h04, 4'hF, 0, 1, 1, 2);
    tbl[2]  = mkv(1, 0, 32'h08, 4'hF, 0, 1, 1, 3);
    tbl[3]  = mkv(1, 0, 32'h0C, 4'hF, 0, 1, 1, 4);
    tbl[4]  = mkv(1, 0, 32'h14, 4'hF, 0, 1, 0, 4);
    tbl[5]  = mkv(1, 0, 32'h20, 4'hA, 1, 1, 1, 4);
    tbl[6]  = mkv(1, 0, 32'h24, 4'hF, 0, 0, 0, 4);
    tbl[7]  = mkv(0, 0, 32'h00, 4'h0, 1, 1, 1, 3);
    tbl[8]  = mkv(0, 0, 32'h00, 4'h0, 1, 1, 1, 2);
    tbl[9]  = mkv(0, 0, 32'h00, 4'h0, 1, 1, 1, 1);
    tbl[10] = mkv(0, 0, 32'h00, 4'h0, 1, 1, 1, 0);
    tbl[11] = mkv(1, 0, 32'h30, 4'hF, 0, 0, 0, 0);

    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].vld, tbl[i].wen, tbl[i].adr, tbl[i].ben,
           tbl[i].rsp, tbl[i].srdy);
      chk($sformatf("tbl%0d_rdy", i), seen_rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
    end

    step(0, 1, 1, 32'h10, 4'h3, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #0;
    step(0, 0, 0, 0, 0, 1, 1);

    for (int i = 0; i < 12; i++) begin
      step(0, i < 10, 0, 32'h100 + 32'(i * 4), 4'(i + 1),
           i >= 2, 1);
      chk("wrap_cnt_le2", cnt <= 3'd2, 1);
    end

    step(0, 1, 0, 32'h200, 4'hF, 0, 1);
    step(0, 1, 1, 32'h204, 4'hF, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    step(0, 1, 0, 32'h300, 4'h5, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
